fft_writeback_pack: RTL and testbench

FFT_WRITEBACK_PACK -- requirements
Module: fft_writeback_pack

---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_wb_fifo.sv | 61 ++++++
 rtl/fft_writeback_pack.sv | 173 +++++++++++++++++
 tb/tb_fft_writeback_pack.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT write-back path.
//   wb_state_t : write-back pass FSM states
//   cword_t    : 32-bit complex word, {real[31:16], imag[15:0]}
//   LANES / WORD_W / BUS_W : lane count and widths of a packed memory word
//   CNT_W      : width of the group count and stride fields
//   halve_word : per-half arithmetic shift right by one
package fft_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BUS_W  = LANES * WORD_W;
    localparam int unsigned CNT_W  = 10;

    typedef logic [WORD_W-1:0] cword_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_t;

    // Real and imaginary halves are shifted independently, each sign-extended.
    function automatic cword_t halve_word(input cword_t w);
        return {w[31], w[31:17], w[15], w[15:1]};
    endfunction

endpackage

// File: rtl/fft_wb_fifo.sv
// Small synchronous FIFO holding packed write pairs.
//   i_CLK, i_RST_N : clock, asynchronous active-low reset
//   i_PUSH, i_PUSH_DATA : write side (ignored when full)
//   i_POP               : read side (ignored when empty)
//   o_POP_DATA          : head entry, valid while o_EMPTY is low
//   o_FULL, o_EMPTY     : occupancy flags, both registered-derived
// DEPTH must be a power of two (pointers wrap naturally).
module fft_wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_PUSH,
    input  logic [WIDTH-1:0] i_PUSH_DATA,
    input  logic             i_POP,
    output logic [WIDTH-1:0] o_POP_DATA,
    output logic             o_FULL,
    output logic             o_EMPTY
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign o_FULL     = (count_q == FULL_CNT);
    assign o_EMPTY    = (count_q == '0);
    assign do_push    = i_PUSH & ~o_FULL;
    assign do_pop     = i_POP & ~o_EMPTY;
    assign o_POP_DATA = mem[rd_ptr_q];

    // Storage needs no reset: the head is only observed while not empty.
    always_ff @(posedge i_CLK) begin
        if (do_push) begin
            mem[wr_ptr_q] <= i_PUSH_DATA;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fft_writeback_pack.sv
// Packs four butterfly results (top/bottom) into two 128-bit memory words
// according to the stage stride and streams them out through a FIFO.
//   i_CLK, i_RST_N          : clock, asynchronous active-low reset
//   i_START, i_NUM_GROUPS   : begin a pass of NUM_GROUPS butterfly groups
//   i_STRIDE                : stage stride, selects the lane arrangement
//   i_BF_VALID / o_BF_READY : butterfly-result handshake
//   i_BF_TOP0..3, i_BF_BOT0..3, i_ADDR1, i_ADDR2 : group payload
//   o_WR_VALID / i_WR_READY : dual-bank write handshake
//   o_WR_ADDR1/2, o_WR_DATA1/2 : write payload, lane n = bits [32n+31:32n]
//   o_BUSY, o_DONE          : pass in progress, one-cycle completion pulse
// Optional: FFT_WB_SCALE_EN adds i_SCALE, halving every 16-bit half on accept.
module fft_writeback_pack
    import fft_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic              i_START,
    input  logic [CNT_W-1:0]  i_NUM_GROUPS,
    input  logic [CNT_W-1:0]  i_STRIDE,
`ifdef FFT_WB_SCALE_EN
    input  logic              i_SCALE,
`endif
    input  logic              i_BF_VALID,
    output logic              o_BF_READY,
    input  logic [31:0]       i_BF_TOP0,
    input  logic [31:0]       i_BF_TOP1,
    input  logic [31:0]       i_BF_TOP2,
    input  logic [31:0]       i_BF_TOP3,
    input  logic [31:0]       i_BF_BOT0,
    input  logic [31:0]       i_BF_BOT1,
    input  logic [31:0]       i_BF_BOT2,
    input  logic [31:0]       i_BF_BOT3,
    input  logic [ADDR_W-1:0] i_ADDR1,
    input  logic [ADDR_W-1:0] i_ADDR2,
    output logic              o_WR_VALID,
    input  logic              i_WR_READY,
    output logic [ADDR_W-1:0] o_WR_ADDR1,
    output logic [ADDR_W-1:0] o_WR_ADDR2,
    output logic [BUS_W-1:0]  o_WR_DATA1,
    output logic [BUS_W-1:0]  o_WR_DATA2,
    output logic              o_BUSY,
    output logic              o_DONE
);

    localparam int unsigned ENTRY_W = 2 * ADDR_W + 2 * BUS_W;

    wb_state_t          state_q;
    logic [CNT_W-1:0]   num_groups_q;
    logic [CNT_W-1:0]   grp_cnt_q;
    logic               busy_q;
    logic               done_q;

    logic               scale;
    cword_t             top_raw [LANES];
    cword_t             bot_raw [LANES];
    cword_t             top_w   [LANES];
    cword_t             bot_w   [LANES];
    logic [BUS_W-1:0]   pack_d1;
    logic [BUS_W-1:0]   pack_d2;

    logic               accept;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ENTRY_W-1:0] wr_bus;

`ifdef FFT_WB_SCALE_EN
    assign scale = i_SCALE;
`else
    assign scale = 1'b0;
`endif

    assign top_raw[0] = i_BF_TOP0;
    assign top_raw[1] = i_BF_TOP1;
    assign top_raw[2] = i_BF_TOP2;
    assign top_raw[3] = i_BF_TOP3;
    assign bot_raw[0] = i_BF_BOT0;
    assign bot_raw[1] = i_BF_BOT1;
    assign bot_raw[2] = i_BF_BOT2;
    assign bot_raw[3] = i_BF_BOT3;

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            top_w[k] = scale ? halve_word(top_raw[k]) : top_raw[k];
            bot_w[k] = scale ? halve_word(bot_raw[k]) : bot_raw[k];
        end
    end

    // Lane arrangement follows the stride so that each memory word holds
    // the points that land in the same row for the next stage.
    always_comb begin
        pack_d1 = '0;
        pack_d2 = '0;
        if (i_STRIDE > CNT_W'(2)) begin
            pack_d1 = {top_w[3], top_w[2], top_w[1], top_w[0]};
            pack_d2 = {bot_w[3], bot_w[2], bot_w[1], bot_w[0]};
        end else if (i_STRIDE == CNT_W'(2)) begin
            pack_d1 = {bot_w[1], bot_w[0], top_w[1], top_w[0]};
            pack_d2 = {bot_w[3], bot_w[2], top_w[3], top_w[2]};
        end else begin
            pack_d1 = {bot_w[1], top_w[1], bot_w[0], top_w[0]};
            pack_d2 = {bot_w[3], top_w[3], bot_w[2], top_w[2]};
        end
    end

    // Ready also drops once the requested group count is reached, so the
    // cycle spent in RUN before moving to DRAIN cannot take an extra group.
    assign o_BF_READY = (state_q == ST_RUN) & ~fifo_full & (grp_cnt_q != num_groups_q);
    assign accept     = i_BF_VALID & o_BF_READY;

    fft_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_CLK       (i_CLK),
        .i_RST_N     (i_RST_N),
        .i_PUSH      (accept),
        .i_PUSH_DATA ({i_ADDR1, i_ADDR2, pack_d1, pack_d2}),
        .i_POP       (o_WR_VALID & i_WR_READY),
        .o_POP_DATA  (fifo_head),
        .o_FULL      (fifo_full),
        .o_EMPTY     (fifo_empty)
    );

    // Payload is forced to zero while nothing is queued.
    assign o_WR_VALID = ~fifo_empty;
    assign wr_bus     = fifo_empty ? '0 : fifo_head;
    assign {o_WR_ADDR1, o_WR_ADDR2, o_WR_DATA1, o_WR_DATA2} = wr_bus;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q      <= ST_IDLE;
            num_groups_q <= '0;
            grp_cnt_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            if (accept) grp_cnt_q <= grp_cnt_q + CNT_W'(1);
            case (state_q)
                ST_IDLE: begin
                    if (i_START) begin
                        num_groups_q <= i_NUM_GROUPS;
                        grp_cnt_q    <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (grp_cnt_q == num_groups_q) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_BUSY = busy_q;
    assign o_DONE = done_q;

endmodule

// File: tb/tb_fft_writeback_pack.sv
module tb_fft_writeback_pack;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [9:0]        num_groups = '0;
    logic [9:0]        stride = '0;
    logic              scale = 1'b0;
    logic              bf_valid = 1'b0;
    logic [31:0]       tt [4];
    logic [31:0]       bb [4];
    logic [ADDR_W-1:0] addr1 = '0;
    logic [ADDR_W-1:0] addr2 = '0;
    logic              wr_ready = 1'b0;

    logic              o_BF_READY;
    logic              o_WR_VALID;
    logic [ADDR_W-1:0] o_WR_ADDR1;
    logic [ADDR_W-1:0] o_WR_ADDR2;
    logic [127:0]      o_WR_DATA1;
    logic [127:0]      o_WR_DATA2;
    logic              o_BUSY;
    logic              o_DONE;

    fft_writeback_pack #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .i_CLK        (clk),
        .i_RST_N      (rst_n),
        .i_START      (start),
        .i_NUM_GROUPS (num_groups),
        .i_STRIDE     (stride),
`ifdef FFT_WB_SCALE_EN
        .i_SCALE      (scale),
`endif
        .i_BF_VALID   (bf_valid),
        .o_BF_READY   (o_BF_READY),
        .i_BF_TOP0    (tt[0]),
        .i_BF_TOP1    (tt[1]),
        .i_BF_TOP2    (tt[2]),
        .i_BF_TOP3    (tt[3]),
        .i_BF_BOT0    (bb[0]),
        .i_BF_BOT1    (bb[1]),
        .i_BF_BOT2    (bb[2]),
        .i_BF_BOT3    (bb[3]),
        .i_ADDR1      (addr1),
        .i_ADDR2      (addr2),
        .o_WR_VALID   (o_WR_VALID),
        .i_WR_READY   (wr_ready),
        .o_WR_ADDR1   (o_WR_ADDR1),
        .o_WR_ADDR2   (o_WR_ADDR2),
        .o_WR_DATA1   (o_WR_DATA1),
        .o_WR_DATA2   (o_WR_DATA2),
        .o_BUSY       (o_BUSY),
        .o_DONE       (o_DONE)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int done_cnt = 0;

    typedef struct {
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
        logic [127:0]      d1;
        logic [127:0]      d2;
    } wr_t;

    wr_t model_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference packing: list the eight words in memory order, then split
    // the list into two memory words of four lanes each.
    function automatic wr_t model_pack(input logic [9:0] s_in, input logic sc,
                                       input logic [31:0] t [4], input logic [31:0] b [4],
                                       input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        wr_t e;
        logic [31:0] seq [8];
        logic [31:0] w;
        logic signed [15:0] re;
        logic signed [15:0] im;
        int s;
        s = (s_in == 0) ? 1 : int'(s_in);
        for (int k = 0; k < 8; k++) begin
            if (s > 2)       w = (k < 4) ? t[k] : b[k-4];
            else if (s == 2) w = ((k % 4) < 2) ? t[2*(k/4) + (k%4)] : b[2*(k/4) + (k%4) - 2];
            else             w = (k % 2 == 0) ? t[k/2] : b[k/2];
            if (sc) begin
                re = w[31:16];
                im = w[15:0];
                re = re >>> 1;
                im = im >>> 1;
                w  = {re, im};
            end
            seq[k] = w;
        end
        e.a1 = a1;
        e.a2 = a2;
        e.d1 = {seq[3], seq[2], seq[1], seq[0]};
        e.d2 = {seq[7], seq[6], seq[5], seq[4]};
        return e;
    endfunction

    // Model bookkeeping at each active edge (values seen are pre-edge).
    always @(posedge clk or negedge rst_n) begin
        wr_t tmp;
        if (!rst_n) begin
            model_q.delete();
        end else begin
            if (o_DONE) done_cnt++;
            if (o_WR_VALID && wr_ready) begin
                wr_count++;
                if (model_q.size() > 0) tmp = model_q.pop_front();
            end
            if (bf_valid && o_BF_READY)
                model_q.push_back(model_pack(stride, scale, tt, bb, addr1, addr2));
        end
    end

    // Per-cycle compare against the model head.
    always @(negedge clk) begin
        if (rst_n) begin
            check("wr_valid", o_WR_VALID, model_q.size() != 0);
            if (o_WR_VALID && model_q.size() != 0) begin
                check("wr_addr1", o_WR_ADDR1, model_q[0].a1);
                check("wr_addr2", o_WR_ADDR2, model_q[0].a2);
                check("wr_data1", o_WR_DATA1, model_q[0].d1);
                check("wr_data2", o_WR_DATA2, model_q[0].d2);
            end
        end
    end

    task automatic send_raw();
        bit got;
        @(posedge clk);
        #1;
        bf_valid = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            got = o_BF_READY;
            @(posedge clk);
        end
        #1;
        bf_valid = 1'b0;
        if (!got) check("accept_timeout", 0, 1);
    endtask

    task automatic send_group(input logic [9:0] s, input logic [31:0] base,
                              input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        stride = s;
        for (int k = 0; k < 4; k++) begin
            tt[k] = base + 32'(k);
            bb[k] = base + 32'(4 + k);
        end
        addr1 = a1;
        addr2 = a2;
        send_raw();
    endtask

    task automatic start_pass(input logic [9:0] n);
        @(posedge clk);
        #1;
        start = 1'b1;
        num_groups = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            seen = o_DONE;
        end
        check("done_seen", seen, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, o_BF_READY, 0);
        check({tag, "_valid"}, o_WR_VALID, 0);
        check({tag, "_busy"},  o_BUSY, 0);
        check({tag, "_done"},  o_DONE, 0);
        check({tag, "_addr"},  {o_WR_ADDR1, o_WR_ADDR2}, 0);
        check({tag, "_data"},  {o_WR_DATA1, o_WR_DATA2}, 0);
    endtask

    initial begin
        int wr0;
        int dn0;
        for (int k = 0; k < 4; k++) begin
            tt[k] = '0;
            bb[k] = '0;
        end

        // Reset state
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_release_valid", o_WR_VALID, 0);
        check("post_release_busy", o_BUSY, 0);

        // Valid in IDLE is never taken
        bf_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_ready", o_BF_READY, 0);
        end
        bf_valid = 1'b0;

        // Packing for the three stride classes, fixed data T=1..4, B=5..8
        wr_ready = 1'b1;
        dn0 = done_cnt;
        start_pass(3);
        check("run_busy", o_BUSY, 1);
        send_group(10'd4, 32'd1, 10'd16, 10'd17);
        @(negedge clk);
        check("s4_d1", o_WR_DATA1, {32'd4, 32'd3, 32'd2, 32'd1});
        check("s4_d2", o_WR_DATA2, {32'd8, 32'd7, 32'd6, 32'd5});
        check("s4_a1", o_WR_ADDR1, 10'd16);
        send_group(10'd2, 32'd1, 10'd32, 10'd33);
        @(negedge clk);
        check("s2_d1", o_WR_DATA1, {32'd6, 32'd5, 32'd2, 32'd1});
        check("s2_d2", o_WR_DATA2, {32'd8, 32'd7, 32'd4, 32'd3});
        send_group(10'd1, 32'd1, 10'd48, 10'd49);
        @(negedge clk);
        check("s1_d1", o_WR_DATA1, {32'd6, 32'd2, 32'd5, 32'd1});
        check("s1_d2", o_WR_DATA2, {32'd8, 32'd4, 32'd7, 32'd3});
        wait_done();
        check("pass1_done_pulses", done_cnt - dn0, 1);

        // Backpressure: FIFO fills after two groups, then drains in order
        wr_ready = 1'b0;
        wr0 = wr_count;
        dn0 = done_cnt;
        start_pass(5);
        send_group(10'd8, 32'h100, 10'd100, 10'd200);
        send_group(10'd0, 32'h200, 10'd101, 10'd201);
        stride = 10'd2;
        for (int k = 0; k < 4; k++) begin
            tt[k] = 32'h300 + 32'(k);
            bb[k] = 32'h304 + 32'(k);
        end
        addr1 = 10'd102;
        addr2 = 10'd202;
        bf_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_ready", o_BF_READY, 0);
            check("full_valid", o_WR_VALID, 1);
        end
        wr_ready = 1'b1;
        send_raw();
        send_group(10'd1, 32'h400, 10'd103, 10'd203);
        send_group(10'd16, 32'h500, 10'd104, 10'd204);
        wait_done();
        check("bp_writes", wr_count - wr0, 5);
        check("bp_done_pulses", done_cnt - dn0, 1);

        // Zero groups: DONE two edges after the edge that samples START
        wr0 = wr_count;
        @(posedge clk);
        #1;
        start = 1'b1;
        num_groups = 10'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("zero_done", o_DONE, k == 2);
            check("zero_busy", o_BUSY, k < 2);
            check("zero_valid", o_WR_VALID, 0);
        end
        check("zero_writes", wr_count - wr0, 0);

        // Reset in DRAIN with two queued entries
        wr_ready = 1'b0;
        start_pass(2);
        send_group(10'd4, 32'h600, 10'd300, 10'd400);
        send_group(10'd4, 32'h700, 10'd301, 10'd401);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("drain_busy", o_BUSY, 1);
        check("drain_valid", o_WR_VALID, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_ready = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");
        repeat (3) @(negedge clk);
        check("after_reset_idle_busy", o_BUSY, 0);

`ifdef FFT_WB_SCALE_EN
        // Scaling: every half shifted right arithmetically
        start_pass(1);
        scale = 1'b1;
        stride = 10'd4;
        for (int k = 0; k < 4; k++) begin
            tt[k] = 32'h8000_0002;
            bb[k] = 32'h8000_0002;
        end
        send_raw();
        scale = 1'b0;
        @(negedge clk);
        check("scale_lane0", o_WR_DATA1[31:0], 32'hC000_0001);
        wait_done();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
